// File: rtl/md_sched.sv
// HI/LO multiply/divide scheduler: fixed-latency mult/div, mthi/mtlo writes,
// and the D-stage stall request while an operation is in flight.
module md_sched #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        e_valid,
  input  logic [3:0]  e_md_op,
  input  logic [31:0] e_rs,
  input  logic [31:0] e_rt,
  input  logic        d_md_use,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        busy,
  output logic        stall
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;

  localparam logic [3:0] MULT_N = MULT_CYCLES[3:0];
  localparam logic [3:0] DIV_N  = DIV_CYCLES[3:0];

  typedef enum logic {IDLE, RUN} state_e;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        wr;
  } pend_t;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  pend_t       pend_q, pend_d;

  logic        start, is_div, is_signed;
  logic [63:0] op_a64, op_b64, prod;
  logic        neg_a, neg_b;
  logic [31:0] mag_a, mag_b, div_b, q_mag, r_mag, quot, rem;

  // Signed divide is done on magnitudes so 0x80000000 / -1 folds to
  // 0x80000000 rem 0 without relying on simulator overflow behaviour.
  always_comb begin
    is_div    = (e_md_op == OP_DIV) || (e_md_op == OP_DIVU);
    is_signed = (e_md_op == OP_MULT) || (e_md_op == OP_DIV);
    start     = e_valid && (state_q == IDLE) &&
                (e_md_op >= OP_MULT) && (e_md_op <= OP_DIVU);

    op_a64 = {{32{is_signed & e_rs[31]}}, e_rs};
    op_b64 = {{32{is_signed & e_rt[31]}}, e_rt};
    prod   = op_a64 * op_b64;

    neg_a = is_signed & e_rs[31];
    neg_b = is_signed & e_rt[31];
    mag_a = neg_a ? (~e_rs + 32'd1) : e_rs;
    mag_b = neg_b ? (~e_rt + 32'd1) : e_rt;
    div_b = (mag_b == 32'd0) ? 32'd1 : mag_b;
    q_mag = mag_a / div_b;
    r_mag = mag_a % div_b;
    quot  = (neg_a ^ neg_b) ? (~q_mag + 32'd1) : q_mag;
    rem   = neg_a ? (~r_mag + 32'd1) : r_mag;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    pend_d  = pend_q;
    if (state_q == IDLE) begin
      if (start) begin
        state_d   = RUN;
        cnt_d     = is_div ? DIV_N : MULT_N;
        pend_d.hi = is_div ? rem  : prod[63:32];
        pend_d.lo = is_div ? quot : prod[31:0];
        pend_d.wr = !(is_div && (e_rt == 32'd0));
      end else if (e_valid && (e_md_op == OP_MTHI)) begin
        hi_d = e_rs;
      end else if (e_valid && (e_md_op == OP_MTLO)) begin
        lo_d = e_rs;
      end
    end else begin
      // E-stage ops are ignored here; stall keeps them out of E.
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        state_d = IDLE;
        if (pend_q.wr) begin
          hi_d = pend_q.hi;
          lo_d = pend_q.lo;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      pend_q  <= pend_d;
    end
  end

  assign hi_out = hi_q;
  assign lo_out = lo_q;
  assign busy   = (state_q == RUN);
  assign stall  = d_md_use & (busy | start);

endmodule
